// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op codes and bus layouts for the MEM stage and its neighbours.
package mem_stage_pkg;

  localparam int unsigned EX_TO_MEM_BUS_WD = 75;
  localparam int unsigned MEM_TO_WB_BUS_WD = 104;
  localparam int unsigned MEM_FWD_BUS_WD   = 39;
  localparam int unsigned DATA_WD          = 32;
  localparam int unsigned REG_ADDR_WD      = 5;

  localparam logic [2:0] LOAD_OP_LW  = 3'b000;
  localparam logic [2:0] LOAD_OP_LB  = 3'b001;
  localparam logic [2:0] LOAD_OP_LBU = 3'b010;
  localparam logic [2:0] LOAD_OP_LH  = 3'b011;
  localparam logic [2:0] LOAD_OP_LHU = 3'b100;

  // Register-file write-data source selects
  localparam logic [1:0] SEL_WD_ALU  = 2'b00;
  localparam logic [1:0] SEL_WD_LINK = 2'b01;
  localparam logic [1:0] SEL_WD_LOAD = 2'b10;
  localparam logic [1:0] SEL_WD_ZERO = 2'b11;

  typedef struct packed {
    logic [DATA_WD-1:0]     pc_plus_4;
    logic [DATA_WD-1:0]     alu_res;
    logic [REG_ADDR_WD-1:0] w_addr;
    logic [1:0]             sel_rf_w_data;
    logic                   sel_rf_w_en;
    logic [2:0]             load_op;
  } ex_to_mem_t;

  typedef struct packed {
    logic [DATA_WD-1:0]     pc_plus_4;
    logic [DATA_WD-1:0]     alu_res;
    logic [DATA_WD-1:0]     rdata;
    logic [REG_ADDR_WD-1:0] w_addr;
    logic [1:0]             sel_rf_w_data;
    logic                   sel_rf_w_en;
  } mem_to_wb_t;

  typedef struct packed {
    logic [DATA_WD-1:0]     w_data;
    logic [REG_ADDR_WD-1:0] w_addr;
    logic                   w_en;
    logic                   mem_valid;
  } mem_fwd_t;

endpackage

// File: rtl/mem_load_align.sv
// Little-endian load alignment and sign/zero extension of a 32-bit RAM word.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [DATA_WD-1:0] raw_rdata,
  input  logic [1:0]         off,
  input  logic [2:0]         load_op,
  output logic [DATA_WD-1:0] load_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword select uses off[1] only; off[0] is ignored for halfwords
  always_comb begin
    byte_sel = raw_rdata[7:0];
    case (off)
      2'd1:    byte_sel = raw_rdata[15:8];
      2'd2:    byte_sel = raw_rdata[23:16];
      2'd3:    byte_sel = raw_rdata[31:24];
      default: byte_sel = raw_rdata[7:0];
    endcase
    half_sel = off[1] ? raw_rdata[31:16] : raw_rdata[15:0];
  end

  // Unassigned op codes fall back to a full-word load
  always_comb begin
    load_data_c = raw_rdata;
    case (load_op)
      LOAD_OP_LB:  load_data_c = {{24{byte_sel[7]}}, byte_sel};
      LOAD_OP_LBU: load_data_c = {24'd0, byte_sel};
      LOAD_OP_LH:  load_data_c = {{16{half_sel[15]}}, half_sel};
      LOAD_OP_LHU: load_data_c = {16'd0, half_sel};
      default:     load_data_c = raw_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM register, SRAM read-data hold across WB stalls,
// load alignment, and the MEM->WB payload plus ID bypass bus.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_bus,
  input  logic                        EX_to_MEM_valid,
  output logic                        MEM_allow_in,
  input  logic [DATA_WD-1:0]          data_ram_r_data,
  output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,
  output logic                        MEM_to_WB_valid,
  input  logic                        WB_allow_in,
  output logic [MEM_FWD_BUS_WD-1:0]   MEM_to_ID_fwd_bus
);

  ex_to_mem_t         payload_q;
  logic               mem_valid_q;
  logic               first_cycle_q;
  logic [DATA_WD-1:0] rdata_buf_q;

  logic               load_en;
  logic [DATA_WD-1:0] raw_rdata;
  logic [DATA_WD-1:0] load_data;
  logic [DATA_WD-1:0] fwd_data;
  mem_to_wb_t         wb_bus;
  mem_fwd_t           fwd_bus;

  // MEM always completes in one cycle, so only WB back-pressure can stall it
  assign MEM_allow_in    = ~mem_valid_q | WB_allow_in;
  assign MEM_to_WB_valid = mem_valid_q;
  assign load_en         = EX_to_MEM_valid & MEM_allow_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q   <= 1'b0;
      first_cycle_q <= 1'b0;
      rdata_buf_q   <= '0;
      payload_q     <= '0;
    end else begin
      if (MEM_allow_in) begin
        mem_valid_q <= EX_to_MEM_valid;
      end
      if (load_en) begin
        payload_q <= EX_to_MEM_bus;
      end
      if (load_en) begin
        first_cycle_q <= 1'b1;
      end else if (!WB_allow_in) begin
        first_cycle_q <= 1'b0;
      end
      // SRAM output is only valid in the entry's first cycle; keep it for the stall
      if (mem_valid_q && first_cycle_q && !WB_allow_in) begin
        rdata_buf_q <= data_ram_r_data;
      end
    end
  end

  assign raw_rdata = first_cycle_q ? data_ram_r_data : rdata_buf_q;

  mem_load_align u_load_align (
    .raw_rdata   (raw_rdata),
    .off         (payload_q.alu_res[1:0]),
    .load_op     (payload_q.load_op),
    .load_data_c (load_data)
  );

  always_comb begin
    fwd_data = payload_q.alu_res;
    case (payload_q.sel_rf_w_data)
      SEL_WD_LOAD: fwd_data = load_data;
      SEL_WD_LINK: fwd_data = payload_q.pc_plus_4 + DATA_WD'(4);
      SEL_WD_ZERO: fwd_data = '0;
      default:     fwd_data = payload_q.alu_res;
    endcase
  end

  always_comb begin
    wb_bus.pc_plus_4     = payload_q.pc_plus_4;
    wb_bus.alu_res       = payload_q.alu_res;
    wb_bus.rdata         = load_data;
    wb_bus.w_addr        = payload_q.w_addr;
    wb_bus.sel_rf_w_data = payload_q.sel_rf_w_data;
    wb_bus.sel_rf_w_en   = payload_q.sel_rf_w_en;

    fwd_bus.w_data    = fwd_data;
    fwd_bus.w_addr    = payload_q.w_addr;
    fwd_bus.w_en      = payload_q.sel_rf_w_en & mem_valid_q;
    fwd_bus.mem_valid = mem_valid_q;
  end

  assign MEM_to_WB_bus     = wb_bus;
  assign MEM_to_ID_fwd_bus = fwd_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of load/forward vectors through a scoreboard, plus stall and reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                        clk;
  logic                        reset;
  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_bus;
  logic                        EX_to_MEM_valid;
  logic                        MEM_allow_in;
  logic [DATA_WD-1:0]          data_ram_r_data;
  logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus;
  logic                        MEM_to_WB_valid;
  logic                        WB_allow_in;
  logic [MEM_FWD_BUS_WD-1:0]   MEM_to_ID_fwd_bus;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [4:0]  waddr;
    logic [1:0]  sel;
    logic        wen;
    logic [2:0]  op;
    logic [31:0] sram;
    logic [31:0] exp_rdata;
    logic [31:0] exp_fwd;
  } vec_t;

  vec_t        sb[$];
  vec_t        tbl[$];
  vec_t        cur;
  int          checks = 0;
  int          failures = 0;
  logic        take_q = 1'b0;
  logic [31:0] take_data = '0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EX_to_MEM_bus     (EX_to_MEM_bus),
    .EX_to_MEM_valid   (EX_to_MEM_valid),
    .MEM_allow_in      (MEM_allow_in),
    .data_ram_r_data   (data_ram_r_data),
    .MEM_to_WB_bus     (MEM_to_WB_bus),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .WB_allow_in       (WB_allow_in),
    .MEM_to_ID_fwd_bus (MEM_to_ID_fwd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] pc4, input logic [31:0] alu, input logic [4:0] waddr,
                              input logic [1:0] sel, input logic wen, input logic [2:0] op,
                              input logic [31:0] sram, input logic [31:0] exp_rdata, input logic [31:0] exp_fwd);
    vec_t v;
    v.pc4 = pc4; v.alu = alu; v.waddr = waddr; v.sel = sel; v.wen = wen; v.op = op;
    v.sram = sram; v.exp_rdata = exp_rdata; v.exp_fwd = exp_fwd;
    return v;
  endfunction

  function automatic logic [EX_TO_MEM_BUS_WD-1:0] ex_bus(input vec_t v);
    ex_to_mem_t e;
    e.pc_plus_4 = v.pc4; e.alu_res = v.alu; e.w_addr = v.waddr;
    e.sel_rf_w_data = v.sel; e.sel_rf_w_en = v.wen; e.load_op = v.op;
    return e;
  endfunction

  function automatic logic [MEM_TO_WB_BUS_WD-1:0] exp_wb(input vec_t v);
    mem_to_wb_t w;
    w.pc_plus_4 = v.pc4; w.alu_res = v.alu; w.rdata = v.exp_rdata;
    w.w_addr = v.waddr; w.sel_rf_w_data = v.sel; w.sel_rf_w_en = v.wen;
    return w;
  endfunction

  function automatic logic [MEM_FWD_BUS_WD-1:0] exp_fwd(input vec_t v);
    mem_fwd_t f;
    f.w_data = v.exp_fwd; f.w_addr = v.waddr; f.w_en = v.wen; f.mem_valid = 1'b1;
    return f;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare the held entry every valid cycle, pop on transfer, push on accept
  always @(negedge clk) begin
    if (MEM_to_WB_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 128'(MEM_to_WB_valid), 128'(0));
      end else begin
        chk("wb_bus", 128'(MEM_to_WB_bus), 128'(exp_wb(sb[0])));
        chk("fwd_bus", 128'(MEM_to_ID_fwd_bus), 128'(exp_fwd(sb[0])));
        if (WB_allow_in) void'(sb.pop_front());
      end
    end
    if (reset) sb.delete();
    else if (EX_to_MEM_valid && MEM_allow_in) sb.push_back(cur);
    take_q    = EX_to_MEM_valid && MEM_allow_in && !reset;
    take_data = cur.sram;
  end

  // SRAM model: read data valid only in the cycle after the request, garbage otherwise
  always @(posedge clk) begin
    #1;
    data_ram_r_data = take_q ? take_data : $urandom();
  end

  task automatic send(input vec_t v, output int waits, output logic vseen);
    waits = 0;
    cur = v;
    EX_to_MEM_bus = ex_bus(v);
    EX_to_MEM_valid = 1'b1;
    do begin
      @(negedge clk);
      waits++;
    end while (!MEM_allow_in && waits < 50);
    vseen = MEM_to_WB_valid;
    if (!MEM_allow_in) chk("send_timeout", 128'(MEM_allow_in), 128'(1));
    @(posedge clk);
    #1;
    EX_to_MEM_valid = 1'b0;
  endtask

  initial begin
    int   w;
    logic vs;
    vec_t a;
    vec_t b;
    vec_t c;

    reset = 1'b1;
    EX_to_MEM_valid = 1'b0;
    EX_to_MEM_bus = '0;
    WB_allow_in = 1'b1;
    data_ram_r_data = '0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 128'(MEM_to_WB_valid), 128'(0));
    chk("reset_allow_in", 128'(MEM_allow_in), 128'(1));
    chk("reset_wb_bus", 128'(MEM_to_WB_bus), 128'(0));
    chk("reset_fwd_bus", 128'(MEM_to_ID_fwd_bus), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    tbl.push_back(mk(32'h00400010, 32'h00000100, 5'd3,  2'b10, 1'b1, 3'd0, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB));
    tbl.push_back(mk(32'h00400014, 32'h00000102, 5'd4,  2'b10, 1'b1, 3'd1, 32'h12F45678, 32'hFFFFFFF4, 32'hFFFFFFF4));
    tbl.push_back(mk(32'h00400018, 32'h00000102, 5'd5,  2'b10, 1'b1, 3'd2, 32'h12F45678, 32'h000000F4, 32'h000000F4));
    tbl.push_back(mk(32'h0040001C, 32'h00000102, 5'd6,  2'b10, 1'b1, 3'd3, 32'h12F45678, 32'h000012F4, 32'h000012F4));
    tbl.push_back(mk(32'h00400020, 32'h00000100, 5'd7,  2'b10, 1'b1, 3'd4, 32'h12F45678, 32'h00005678, 32'h00005678));
    tbl.push_back(mk(32'h00400024, 32'h00000200, 5'd8,  2'b10, 1'b1, 3'd1, 32'h12F45678, 32'h00000078, 32'h00000078));
    tbl.push_back(mk(32'h00400028, 32'h00000201, 5'd9,  2'b10, 1'b1, 3'd1, 32'h00008000, 32'hFFFFFF80, 32'hFFFFFF80));
    tbl.push_back(mk(32'h0040002C, 32'h00000203, 5'd10, 2'b10, 1'b1, 3'd2, 32'h80123456, 32'h00000080, 32'h00000080));
    tbl.push_back(mk(32'h00400030, 32'h00000001, 5'd11, 2'b10, 1'b1, 3'd3, 32'h00008001, 32'hFFFF8001, 32'hFFFF8001));
    tbl.push_back(mk(32'h00400034, 32'h00000002, 5'd12, 2'b10, 1'b1, 3'd4, 32'h80001234, 32'h00008000, 32'h00008000));
    tbl.push_back(mk(32'h00400038, 32'h00000003, 5'd13, 2'b10, 1'b1, 3'd3, 32'h80001234, 32'hFFFF8000, 32'hFFFF8000));
    tbl.push_back(mk(32'h0040003C, 32'h00000003, 5'd14, 2'b10, 1'b1, 3'd5, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D));
    tbl.push_back(mk(32'h00400040, 32'h00000001, 5'd15, 2'b10, 1'b1, 3'd7, 32'h01234567, 32'h01234567, 32'h01234567));
    tbl.push_back(mk(32'hFFFFFFFC, 32'h00001234, 5'd31, 2'b01, 1'b1, 3'd0, 32'h00000055, 32'h00000055, 32'h00000000));
    tbl.push_back(mk(32'h00400020, 32'h00000008, 5'd31, 2'b01, 1'b1, 3'd1, 32'h000000AB, 32'hFFFFFFAB, 32'h00400024));
    tbl.push_back(mk(32'h00400048, 32'h00000010, 5'd16, 2'b11, 1'b1, 3'd0, 32'h00000077, 32'h00000077, 32'h00000000));
    tbl.push_back(mk(32'h0040004C, 32'hABCD0000, 5'd17, 2'b00, 1'b1, 3'd0, 32'h11111111, 32'h11111111, 32'hABCD0000));
    tbl.push_back(mk(32'h00400050, 32'h00000001, 5'd18, 2'b10, 1'b0, 3'd2, 32'h0000C300, 32'h000000C3, 32'h000000C3));

    // Back-to-back entries, WB always ready
    foreach (tbl[i]) begin
      send(tbl[i], w, vs);
      chk("b2b_accept_wait", 128'(w), 128'(1));
      chk("b2b_prev_valid", 128'(vs), 128'(i > 0));
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bubble_valid", 128'(MEM_to_WB_valid), 128'(0));
    chk("bubble_allow_in", 128'(MEM_allow_in), 128'(1));
    @(posedge clk);
    #1;

    // Stall: held load keeps its first-cycle SRAM data; then leave-and-enter in one cycle
    a = mk(32'h00400100, 32'h00000000, 5'd8, 2'b10, 1'b1, 3'd0, 32'h13579BDF, 32'h13579BDF, 32'h13579BDF);
    b = mk(32'h00400104, 32'h00000003, 5'd9, 2'b10, 1'b1, 3'd1, 32'h9A000000, 32'hFFFFFF9A, 32'hFFFFFF9A);
    WB_allow_in = 1'b0;
    send(a, w, vs);
    cur = b;
    EX_to_MEM_bus = ex_bus(b);
    EX_to_MEM_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_allow_in", 128'(MEM_allow_in), 128'(0));
      chk("stall_valid", 128'(MEM_to_WB_valid), 128'(1));
      @(posedge clk);
      #1;
    end
    WB_allow_in = 1'b1;
    @(negedge clk);
    chk("release_allow_in", 128'(MEM_allow_in), 128'(1));
    @(posedge clk);
    #1;
    EX_to_MEM_valid = 1'b0;
    WB_allow_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall2_allow_in", 128'(MEM_allow_in), 128'(0));
      @(posedge clk);
      #1;
    end
    WB_allow_in = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_stall_empty", 128'(MEM_to_WB_valid), 128'(0));
    @(posedge clk);
    #1;

    // Reset while stalled: held entry is dropped and never delivered
    c = mk(32'h00400200, 32'h00000004, 5'd10, 2'b10, 1'b1, 3'd0, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D);
    WB_allow_in = 1'b0;
    send(c, w, vs);
    @(negedge clk);
    chk("pre_reset_valid", 128'(MEM_to_WB_valid), 128'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_valid", 128'(MEM_to_WB_valid), 128'(0));
    chk("midreset_allow_in", 128'(MEM_allow_in), 128'(1));
    chk("midreset_wb_bus", 128'(MEM_to_WB_bus), 128'(0));
    chk("midreset_fwd_bus", 128'(MEM_to_ID_fwd_bus), 128'(0));
    @(posedge clk);
    #1;
    WB_allow_in = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_ghost_valid", 128'(MEM_to_WB_valid), 128'(0));
    end

    chk("sb_drain", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
